// File: rtl/ring_osc_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_meter_if
//  Description : Request/result bundle for the ring-oscillator frequency
//                meter. The controller (master) drives the request side
//                (start, chan_sel, gate_cycles, continuous). The meter
//                (slave) drives the result side (busy, done, count,
//                overflow, sel_err).
//  Ports       : none (signal bundle only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ring_osc_meter_if #(
  parameter int CHANNELS = 4,
  parameter int GATE_W   = 16,
  parameter int COUNT_W  = 24
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic               start;
  logic [SEL_W-1:0]   chan_sel;
  logic [GATE_W-1:0]  gate_cycles;
  logic               continuous;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               sel_err;

  modport master (
    output start, chan_sel, gate_cycles, continuous,
    input  busy, done, count, overflow, sel_err
  );

  modport slave (
    input  start, chan_sel, gate_cycles, continuous,
    output busy, done, count, overflow, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/ring_osc_meter.sv
`default_nettype none
// ============================================================================
//  Module      : ring_osc_meter
//  Description : Bank of CHANNELS enable-gated LUT ring oscillators with a
//                single-clock frequency meter. The selected ring's prescaler
//                MSB is synchronised into clk, and its rising edges are
//                counted over a programmable gate window. Only the ring
//                being measured is enabled.
//  Ports       : clk    - system clock
//                resetn - asynchronous active-low reset
//                bus    - ring_osc_meter_if.slave: start/chan_sel/
//                         gate_cycles/continuous in; busy/done/count/
//                         overflow/sel_err out
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_osc_meter #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 31,
  parameter int PRESCALE = 4,
  parameter int GATE_W   = 16,
  parameter int COUNT_W  = 24,
  parameter int SETTLE   = 8
) (
  input  logic            clk,
  input  logic            resetn,
  ring_osc_meter_if.slave bus
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SEL_W:0]       c_chan_lim    = (SEL_W+1)'(CHANNELS);
  localparam logic [COUNT_W-1:0]   c_count_max   = '1;
  localparam logic [SET_W-1:0]     c_settle_init = SET_W'(SETTLE - 1);
  localparam logic [GATE_W-1:0]    c_gate_last   = GATE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [CHANNELS-1:0]  r_ring_en;
  logic [SEL_W-1:0]     r_sel;
  logic [SET_W-1:0]     r_settle;
  logic [GATE_W-1:0]    r_gate_len;
  logic [GATE_W-1:0]    r_gate_cnt;
  logic [COUNT_W-1:0]   r_edge_cnt;
  logic                 r_ovf_acc;
  logic [2:0]           r_sync;
  logic                 r_busy;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_sel_err;

  logic [CHANNELS-1:0]  w_msb;
  logic                 w_msb_sel;
  logic                 w_edge;
  logic [COUNT_W-1:0]   w_cnt_next;
  logic                 w_ovf_next;
  logic                 w_continue;

  // --------------------------------------------------------------------------
  // Ring bank. Each ring is an odd chain of inverters whose first stage is
  // gated by its enable, so a disabled ring parks at a static level. The
  // prescaler is held clear while the ring is disabled, which also makes a
  // fresh measurement start from a known phase.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ring
      (* ringosc = "true", keep = "true" *) logic [STAGES-1:0] w_stage;
      logic                w_fb;
      logic                w_en;
      logic [PRESCALE-1:0] r_presc;

      assign w_en       = r_ring_en[g];
      assign w_fb       = w_stage[STAGES-1];
      assign w_stage[0] = ~(w_en & w_fb);

      for (genvar s = 1; s < STAGES; s++) begin : g_stage
        assign w_stage[s] = ~w_stage[s-1];
      end

      always_ff @(posedge w_fb or negedge w_en) begin
        if (!w_en) r_presc <= '0;
        else       r_presc <= r_presc + 1'b1;
      end

      assign w_msb[g] = r_presc[PRESCALE-1];
    end
  endgenerate

  // Select the measured ring's MSB; r_sel only ever holds a valid channel.
  always_comb begin
    w_msb_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (r_sel == SEL_W'(i)) w_msb_sel = w_msb[i];
    end
  end

  // Three-flop synchroniser; the edge is taken between stages 2 and 3 so the
  // first stage is never used for logic.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_sync <= '0;
    else         r_sync <= {r_sync[1:0], w_msb_sel};
  end

  assign w_edge = r_sync[1] & ~r_sync[2];

  // Saturating edge accumulator; overflow marks an edge lost at full scale.
  always_comb begin
    w_cnt_next = r_edge_cnt;
    w_ovf_next = r_ovf_acc;
    if (w_edge) begin
      if (r_edge_cnt == c_count_max) w_ovf_next = 1'b1;
      else                           w_cnt_next = r_edge_cnt + 1'b1;
    end
  end

  // A zero-length gate cannot be re-armed, so it never loops in continuous mode.
  assign w_continue = bus.continuous & ~r_sel_err & (r_gate_len != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ring_en  <= '0;
      r_sel      <= '0;
      r_settle   <= '0;
      r_gate_len <= '0;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf_acc  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy     <= 1'b1;
            r_gate_len <= bus.gate_cycles;
            if ({1'b0, bus.chan_sel} >= c_chan_lim) begin
              r_count    <= '0;
              r_overflow <= 1'b0;
              r_sel_err  <= 1'b1;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else if (bus.gate_cycles == '0) begin
              r_count    <= '0;
              r_overflow <= 1'b0;
              r_sel_err  <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_sel     <= bus.chan_sel;
              r_ring_en <= CHANNELS'(1) << bus.chan_sel;
              r_settle  <= c_settle_init;
              r_state   <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle == '0) begin
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
            r_gate_cnt <= r_gate_len;
            r_state    <= S_GATE;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_GATE: begin
          // The edge seen in the last gate cycle is folded straight into the result.
          if (r_gate_cnt == c_gate_last) begin
            r_count    <= w_cnt_next;
            r_overflow <= w_ovf_next;
            r_sel_err  <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_edge_cnt <= w_cnt_next;
            r_ovf_acc  <= w_ovf_next;
            r_gate_cnt <= r_gate_cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Edges detected in this cycle are dropped by clearing the accumulator.
          if (w_continue) begin
            r_edge_cnt <= '0;
            r_ovf_acc  <= 1'b0;
            r_gate_cnt <= r_gate_len;
            r_state    <= S_GATE;
          end else begin
            r_ring_en <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.sel_err  = r_sel_err;

endmodule
`default_nettype wire
